// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_if
// Description : Request/response bundle for the iterative divider.
//               Request side : in_valid/in_ready handshake with a, b, op.
//               Response side: out_valid/out_ready handshake with result.
//               Control      : flush (abort), busy (unit not idle).
//               master = issuing core, slave = div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_unit_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [2:0]      op;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, a, b, op, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, a, b, op, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative radix-2 restoring divider for RV64M
//               (DIV, DIVU, REM, REMU and their W forms).
//               Ports:
//                 clk   - rising-edge clock
//                 reset - asynchronous active-low reset
//                 bus   - div_unit_if.slave: in_valid/in_ready, a, b, op,
//                         flush, out_valid/out_ready, result, busy
//               op[1:0]: 00 div, 01 divu, 10 rem, 11 remu; op[2]: W form.
//               Divide-by-zero and signed overflow finish on the accept edge;
//               otherwise 64 (W: 32) iteration cycles follow the accept edge.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
  parameter int XLEN = 64
) (
  input  wire logic   clk,
  input  wire logic   reset,
  div_unit_if.slave   bus
);

  localparam logic [6:0]      c_iter_dword = 7'd64;
  localparam logic [6:0]      c_iter_word  = 7'd32;
  localparam logic [XLEN-1:0] c_dword_min  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q,     state_d;
  logic [XLEN-1:0] rem_q,       rem_d;
  logic [XLEN-1:0] quo_q,       quo_d;
  logic [XLEN-1:0] dvs_q,       dvs_d;
  logic [XLEN-1:0] result_q,    result_d;
  logic [6:0]      cnt_q,       cnt_d;
  logic            is_rem_q,    is_rem_d;
  logic            is_word_q,   is_word_d;
  logic            q_neg_q,     q_neg_d;
  logic            r_neg_q,     r_neg_d;
  logic            out_valid_q, out_valid_d;

  // --------------------------------------------------------------------------
  // Operand preparation (only meaningful on an accept edge)
  // --------------------------------------------------------------------------
  logic            op_signed, op_rem, op_word;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_as_res, special_res;
  logic            sa, sb, div_zero, overflow;

  always_comb begin
    op_signed = ~bus.op[0];
    op_rem    = bus.op[1];
    op_word   = bus.op[2];

    // Word forms use the low halves, sign- or zero-extended per op.
    if (op_word) begin
      a_ext = {{(XLEN/2){op_signed & bus.a[XLEN/2-1]}}, bus.a[XLEN/2-1:0]};
      b_ext = {{(XLEN/2){op_signed & bus.b[XLEN/2-1]}}, bus.b[XLEN/2-1:0]};
    end else begin
      a_ext = bus.a;
      b_ext = bus.b;
    end

    sa    = op_signed & a_ext[XLEN-1];
    sb    = op_signed & b_ext[XLEN-1];
    // The most-negative value's magnitude still fits as an unsigned number.
    a_mag = sa ? -a_ext : a_ext;
    b_mag = sb ? -b_ext : b_ext;

    div_zero = (b_ext == '0);
    if (op_word) begin
      overflow = op_signed && (bus.a[XLEN/2-1:0] == {1'b1, {(XLEN/2-1){1'b0}}})
                           && (bus.b[XLEN/2-1:0] == {(XLEN/2){1'b1}});
    end else begin
      overflow = op_signed && (bus.a == c_dword_min) && (bus.b == '1);
    end

    // The dividend as an architectural result: W results are always
    // sign-extended from bit 31, even for the unsigned W forms.
    a_as_res = op_word ? {{(XLEN/2){bus.a[XLEN/2-1]}}, bus.a[XLEN/2-1:0]} : bus.a;

    if (div_zero) begin
      special_res = op_rem ? a_as_res : '1;
    end else begin
      special_res = op_rem ? '0 : a_as_res;
    end
  end

  // --------------------------------------------------------------------------
  // One restoring step plus the final sign fixup / result selection
  // --------------------------------------------------------------------------
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            take;
  logic [XLEN-1:0] it_rem, it_quo, q_fix, r_fix, sel_res, final_res;

  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    // rem_q < divisor, so rem_sh < 2*divisor and the 65-bit difference's
    // top bit is a reliable borrow flag.
    diff   = rem_sh - {1'b0, dvs_q};
    take   = ~diff[XLEN];
    it_rem = take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    it_quo = {quo_q[XLEN-2:0], take};

    q_fix     = q_neg_q ? -it_quo : it_quo;
    r_fix     = r_neg_q ? -it_rem : it_rem;
    sel_res   = is_rem_q ? r_fix : q_fix;
    final_res = is_word_q ? {{(XLEN/2){sel_res[XLEN/2-1]}}, sel_res[XLEN/2-1:0]}
                          : sel_res;
  end

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    is_rem_d    = is_rem_q;
    is_word_d   = is_word_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          is_rem_d  = op_rem;
          is_word_d = op_word;
          if (div_zero || overflow) begin
            result_d    = special_res;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            q_neg_d = sa ^ sb;
            r_neg_d = sa;
            dvs_d   = b_mag;
            rem_d   = '0;
            // Word dividends are parked in the upper half so that 32 shifts
            // consume exactly their bits; the quotient lands in the low half.
            quo_d   = op_word ? {a_mag[XLEN/2-1:0], {(XLEN/2){1'b0}}} : a_mag;
            cnt_d   = op_word ? c_iter_word : c_iter_dword;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        rem_d = it_rem;
        quo_d = it_quo;
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          result_d    = final_res;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a same-edge accept.
    if (bus.flush) begin
      out_valid_d = 1'b0;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      is_rem_q    <= 1'b0;
      is_word_q   <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      is_rem_q    <= is_rem_d;
      is_word_q   <= is_word_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit. Results are compared with
//               a behavioural RV64M model built from SystemVerilog arithmetic;
//               latency, backpressure, reset/flush aborts are checked inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

  localparam logic [63:0] c_min64 = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_unit_if #(.XLEN(64)) bus ();

  div_unit #(.XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] op);
    logic               sgn, rem, word;
    logic signed [63:0] sa64, sb64;
    logic signed [31:0] sa32, sb32;
    logic        [31:0] ua32, ub32, r32;
    logic        [63:0] r;
    sgn  = !op[0];
    rem  = op[1];
    word = op[2];
    if (!word) begin
      sa64 = a; sb64 = b;
      if (b == 64'd0)                          r = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (sgn && a == c_min64 && b == '1) r = rem ? 64'd0 : a;
      else if (sgn)                            r = rem ? sa64 % sb64 : sa64 / sb64;
      else                                     r = rem ? a % b : a / b;
    end else begin
      ua32 = a[31:0]; ub32 = b[31:0]; sa32 = a[31:0]; sb32 = b[31:0];
      if (ub32 == 32'd0)                                    r32 = rem ? ua32 : 32'hFFFF_FFFF;
      else if (sgn && ua32 == 32'h8000_0000 && ub32 == '1) r32 = rem ? 32'd0 : ua32;
      else if (sgn)                                         r32 = rem ? sa32 % sb32 : sa32 / sb32;
      else                                                  r32 = rem ? ua32 % ub32 : ua32 / ub32;
      r = {{32{r32[31]}}, r32};
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b,
                                 input logic [2:0] op);
    logic sgn;
    sgn = !op[0];
    if (op[2]) begin
      if (b[31:0] == 32'd0 || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF))
        return 1;
      return 33;
    end
    if (b == 64'd0 || (sgn && a == c_min64 && b == '1)) return 1;
    return 65;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Issues one request and waits for out_valid. lat counts the accept edge
  // as edge 1. Operands are scrambled while the unit is running.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                        output logic [63:0] res, output int lat);
    int n;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      bus.a  = {$urandom, $urandom};
      bus.b  = {$urandom, $urandom};
      bus.op = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!bus.out_valid) begin
      errors++;
      $display("FAIL timeout: out_valid=%0b after %0d edges, required 1", bus.out_valid, lat);
    end
    res = bus.result;
  endtask

  task automatic consume;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake: out_valid=%0b in_ready=%0b, required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 64'd0) begin
      errors++;
      $display("FAIL reset: in_ready=%0b out_valid=%0b busy=%0b result=%h, required 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.result);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic [63:0] exp;
    int          lat;
  } dvec_t;

  task automatic test_directed;
    dvec_t v[9];
    logic [63:0] res;
    int lat;
    v[0] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'b000, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    v[1] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    v[2] = '{64'd5, 64'd0, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    v[3] = '{64'd5, 64'd0, 3'b011, 64'd5, 1};
    v[4] = '{c_min64, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, c_min64, 1};
    v[5] = '{c_min64, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010, 64'd0, 1};
    v[6] = '{64'hFFFF_FFFF_0000_0010, 64'd3, 3'b101, 64'd5, 33};
    v[7] = '{64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 64'hFFFF_FFFF_8000_0000, 1};
    v[8] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 3'b110, 64'd1, 33};
    for (int i = 0; i < 9; i++) begin
      run_op(v[i].a, v[i].b, v[i].op, res, lat);
      checks++;
      if (res !== v[i].exp || lat != v[i].lat) begin
        errors++;
        $display("FAIL directed[%0d]: result=%h lat=%0d, required %h lat=%0d",
                 i, res, lat, v[i].exp, v[i].lat);
      end
      consume();
    end
  endtask

  task automatic test_random;
    logic [63:0] a, b, res, exp;
    logic [2:0]  op;
    int lat, elat;
    for (int i = 0; i < 48; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = 64'($urandom_range(1, 9));
        1: b = -64'($urandom_range(1, 9));
        2: b = {$urandom, 32'd0};
        3: begin a = c_min64; b = '1; end
        4: begin a = {$urandom, 32'h8000_0000}; b = {$urandom, 32'hFFFF_FFFF}; end
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) a = 64'($urandom_range(0, 50));
      exp  = ref_div(a, b, op);
      elat = ref_lat(a, b, op);
      run_op(a, b, op, res, lat);
      checks++;
      if (res !== exp || lat != elat) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h op=%b: result=%h lat=%0d, required %h lat=%0d",
                 i, a, b, op, res, lat, exp, elat);
      end
      consume();
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] res;
    int lat;
    int bad;
    run_op(64'd100, 64'd7, 3'b011, res, lat);
    checks++;
    if (res !== 64'd2 || lat != 65) begin
      errors++;
      $display("FAIL bp_result: result=%h lat=%0d, required 2 lat=65", res, lat);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.result !== 64'd2 || bus.in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
    end
    consume();
  endtask

  task automatic test_back_to_back;
    logic [63:0] res;
    int lat;
    run_op(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 3'b000, res, lat);
    consume();
    run_op(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 3'b010, res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE || lat != 65) begin
      errors++;
      $display("FAIL back_to_back: result=%h lat=%0d, required fffffffffffffffe lat=65", res, lat);
    end
    consume();
  endtask

  task automatic start_long_div;
    @(negedge clk);
    bus.a = 64'd123456789; bus.b = 64'd7; bus.op = 3'b000; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_reset_abort;
    logic [63:0] res;
    int lat;
    start_long_div();
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: out_valid=%0b in_ready=%0b busy=%0b, required 0/1/0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
    @(negedge clk);
    reset = 1'b1;
    run_op(64'd100, 64'd7, 3'b000, res, lat);
    checks++;
    if (res !== 64'd14 || lat != 65) begin
      errors++;
      $display("FAIL after_reset: result=%h lat=%0d, required 14 lat=65", res, lat);
    end
    consume();
  endtask

  task automatic test_flush;
    logic [63:0] res;
    int lat;
    int pulses;
    start_long_div();
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_run: busy=%0b in_ready=%0b out_valid=%0b, required 0/1/0",
               bus.busy, bus.in_ready, bus.out_valid);
    end
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL flush_pulse: out_valid seen %0d times, required 0", pulses);
    end
    // flush while holding a result
    run_op(64'd5, 64'd0, 3'b011, res, lat);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_done: out_valid=%0b in_ready=%0b, required 0/1", bus.out_valid, bus.in_ready);
    end
    // flush beats a same-edge request
    @(negedge clk);
    bus.a = 64'd5; bus.b = 64'd0; bus.op = 3'b001; bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept: busy=%0b out_valid=%0b, required 0/0", bus.busy, bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_abort();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
